// File: rtl/seg_monitor.sv
// ---------------------------------------------------------------------------
// seg_monitor
//   Readback monitor for the seven-segment display path. Synchronizes the
//   divided clock and segment bus, decodes the segment pattern on each falling
//   edge of the divided clock, and checks that successive digits increment
//   modulo MOD. It also measures the divided-clock period in clk cycles and
//   reports lock status and a saturating error count.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   i_ena          in   enable; low freezes everything except synchronizers
//   i_div_clk      in   divided clock, asynchronous to clk
//   i_disp[6:0]    in   segment bus, active-high, bit0=a .. bit6=g
//   o_digit[3:0]   out  last successfully decoded digit
//   o_valid        out  one-cycle pulse per sample taken
//   o_bad_pattern  out  one-cycle pulse: pattern not decodable / digit >= MOD
//   o_seq_err      out  one-cycle pulse: digit is not the expected successor
//   o_locked       out  level: LOCK_N consecutive good increments seen
//   o_err_cnt[7:0] out  total errors, saturating at 255
//   o_period       out  clk cycles between last two rising edges of i_div_clk
// ---------------------------------------------------------------------------
module seg_monitor #(
    parameter int MOD      = 10,
    parameter int LOCK_N   = 4,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_ena,
    input  logic                i_div_clk,
    input  logic [6:0]          i_disp,
    output logic [3:0]          o_digit,
    output logic                o_valid,
    output logic                o_bad_pattern,
    output logic                o_seq_err,
    output logic                o_locked,
    output logic [7:0]          o_err_cnt,
    output logic [PERIOD_W-1:0] o_period
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Returns {ok, digit}; digits at or above the modulus are not legal here.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [3:0] d;
        logic       ok;
        ok = 1'b1;
        case (pat)
            7'h3F: d = 4'h0;
            7'h06: d = 4'h1;
            7'h5B: d = 4'h2;
            7'h4F: d = 4'h3;
            7'h66: d = 4'h4;
            7'h6D: d = 4'h5;
            7'h7D: d = 4'h6;
            7'h07: d = 4'h7;
            7'h7F: d = 4'h8;
            7'h6F: d = 4'h9;
            7'h77: d = 4'hA;
            7'h7C: d = 4'hB;
            7'h39: d = 4'hC;
            7'h5E: d = 4'hD;
            7'h79: d = 4'hE;
            7'h71: d = 4'hF;
            default: begin
                d  = 4'h0;
                ok = 1'b0;
            end
        endcase
        if ({1'b0, d} >= 5'(MOD)) ok = 1'b0;
        return {ok, d};
    endfunction

    function automatic logic [3:0] successor(input logic [3:0] x);
        return (x == 4'(MOD - 1)) ? 4'd0 : x + 4'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] x);
        return (&x) ? x : x + 8'd1;
    endfunction

    function automatic logic [PERIOD_W-1:0] sat_inc_period(input logic [PERIOD_W-1:0] x);
        return (&x) ? x : x + {{(PERIOD_W-1){1'b0}}, 1'b1};
    endfunction

    // Synchronizer stages
    logic       r_s1, r_s2, r_s3;
    logic [6:0] r_d1, r_d2;

    // Monitor state
    state_t              r_state;
    logic [3:0]          r_digit;
    logic [3:0]          r_run;
    logic                r_valid;
    logic                r_bad;
    logic                r_seq;
    logic [7:0]          r_err_cnt;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_seen;

    logic       w_rise, w_fall;
    logic [4:0] w_dec;
    logic       w_dec_ok;
    logic [3:0] w_dec_digit;
    logic [3:0] w_run_inc;

    state_t     w_state_nxt;
    logic [3:0] w_digit_nxt;
    logic [3:0] w_run_nxt;
    logic       w_valid_nxt;
    logic       w_bad_nxt;
    logic       w_seq_nxt;
    logic       w_err_inc;

    // Falls are the sampling point: the segment bus is mid-period and stable.
    assign w_rise      = r_s2 & ~r_s3;
    assign w_fall      = ~r_s2 & r_s3;
    assign w_dec       = seg_decode(r_d2);
    assign w_dec_ok    = w_dec[4];
    assign w_dec_digit = w_dec[3:0];
    assign w_run_inc   = (r_run == 4'(LOCK_N)) ? r_run : r_run + 4'd1;

    // Synchronizers run regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            r_d1 <= 7'd0;
            r_d2 <= 7'd0;
        end else begin
            r_s1 <= i_div_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_d1 <= i_disp;
            r_d2 <= r_d1;
        end
    end

    // Sample evaluation: next state, digit, run length and pulses
    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_run_nxt   = r_run;
        w_valid_nxt = 1'b0;
        w_bad_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
        w_err_inc   = 1'b0;
        if (i_ena && w_fall) begin
            w_valid_nxt = 1'b1;
            if (!w_dec_ok) begin
                w_bad_nxt   = 1'b1;
                w_err_inc   = 1'b1;
                w_run_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end else if (r_state == IDLE) begin
                w_digit_nxt = w_dec_digit;
                w_run_nxt   = 4'd0;
                w_state_nxt = ARMED;
            end else if (w_dec_digit == successor(r_digit)) begin
                w_digit_nxt = w_dec_digit;
                w_run_nxt   = w_run_inc;
                if (w_run_inc == 4'(LOCK_N)) w_state_nxt = LOCKED;
            end else begin
                w_seq_nxt   = 1'b1;
                w_err_inc   = 1'b1;
                w_digit_nxt = w_dec_digit;
                w_run_nxt   = 4'd0;
                w_state_nxt = ARMED;
            end
        end
    end

    // Registered monitor outputs; pulses fall to 0 whenever disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_digit   <= 4'd0;
            r_run     <= 4'd0;
            r_valid   <= 1'b0;
            r_bad     <= 1'b0;
            r_seq     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_valid <= w_valid_nxt;
            r_bad   <= w_bad_nxt;
            r_seq   <= w_seq_nxt;
            if (i_ena) begin
                r_state <= w_state_nxt;
                r_digit <= w_digit_nxt;
                r_run   <= w_run_nxt;
                if (w_err_inc) r_err_cnt <= sat_inc8(r_err_cnt);
            end
        end
    end

    // Period measurement; the first rise after reset only establishes a reference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= '0;
            r_seen   <= 1'b0;
        end else if (i_ena) begin
            if (w_rise) begin
                if (r_seen) r_period <= r_cnt;
                r_cnt  <= {{(PERIOD_W-1){1'b0}}, 1'b1};
                r_seen <= 1'b1;
            end else begin
                r_cnt <= sat_inc_period(r_cnt);
            end
        end
    end

    assign o_digit       = r_digit;
    assign o_valid       = r_valid;
    assign o_bad_pattern = r_bad;
    assign o_seq_err     = r_seq;
    assign o_locked      = (r_state == LOCKED);
    assign o_err_cnt     = r_err_cnt;
    assign o_period      = r_period;

endmodule

// File: tb/tb_seg_monitor.sv
module tb_seg_monitor;

    logic        clk;
    logic        rst_n;
    logic        i_ena;
    logic        i_div_clk;
    logic [6:0]  i_disp;
    logic [3:0]  o_digit;
    logic        o_valid;
    logic        o_bad_pattern;
    logic        o_seq_err;
    logic        o_locked;
    logic [7:0]  o_err_cnt;
    logic [15:0] o_period;

    int checks = 0;
    int errors = 0;

    // Pulse counters gathered on the falling clock edge
    int n_valid = 0;
    int n_bad   = 0;
    int n_seq   = 0;
    int e_valid = 0;
    int e_bad   = 0;
    int e_seq   = 0;

    logic [6:0] seg [16];

    seg_monitor #(.MOD(10), .LOCK_N(4), .PERIOD_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ena         (i_ena),
        .i_div_clk     (i_div_clk),
        .i_disp        (i_disp),
        .o_digit       (o_digit),
        .o_valid       (o_valid),
        .o_bad_pattern (o_bad_pattern),
        .o_seq_err     (o_seq_err),
        .o_locked      (o_locked),
        .o_err_cnt     (o_err_cnt),
        .o_period      (o_period)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (o_valid)       n_valid++;
        if (o_bad_pattern) n_bad++;
        if (o_seq_err)     n_seq++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One divided-clock period: pattern presented with the rising edge,
    // held through the fall; returns one cycle after the low phase ends.
    task automatic sample(input logic [6:0] pat, input int hi, input int lo);
        i_disp    = pat;
        i_div_clk = 1'b1;
        repeat (hi) @(negedge clk);
        i_div_clk = 1'b0;
        repeat (lo) @(negedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [3:0] digit,
                            input logic locked, input logic [7:0] err);
        chk({tag, ".valid"},  n_valid,  e_valid);
        chk({tag, ".bad"},    n_bad,    e_bad);
        chk({tag, ".seq"},    n_seq,    e_seq);
        chk({tag, ".digit"},  o_digit,  digit);
        chk({tag, ".locked"}, o_locked, locked);
        chk({tag, ".err"},    o_err_cnt, err);
    endtask

    initial begin
        seg[0]  = 7'h3F; seg[1]  = 7'h06; seg[2]  = 7'h5B; seg[3]  = 7'h4F;
        seg[4]  = 7'h66; seg[5]  = 7'h6D; seg[6]  = 7'h7D; seg[7]  = 7'h07;
        seg[8]  = 7'h7F; seg[9]  = 7'h6F; seg[10] = 7'h77; seg[11] = 7'h7C;
        seg[12] = 7'h39; seg[13] = 7'h5E; seg[14] = 7'h79; seg[15] = 7'h71;

        rst_n     = 1'b0;
        i_ena     = 1'b1;
        i_div_clk = 1'b0;
        i_disp    = 7'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.digit",  o_digit, 0);
        chk("rst.valid",  o_valid, 0);
        chk("rst.bad",    o_bad_pattern, 0);
        chk("rst.seq",    o_seq_err, 0);
        chk("rst.locked", o_locked, 0);
        chk("rst.err",    o_err_cnt, 0);
        chk("rst.period", o_period, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Clean count 0..9,0,1 at 20-cycle period
        for (int i = 0; i < 12; i++) begin
            sample(seg[i % 10], 10, 10);
            e_valid++;
            step_chk($sformatf("clean%0d", i), 4'(i % 10), (i >= 4), 8'd0);
            chk($sformatf("clean%0d.period", i), o_period, (i == 0) ? 0 : 20);
        end

        // Skip 3 -> 5 while locked
        sample(seg[2], 10, 10); e_valid++;
        step_chk("skip.d2", 4'd2, 1'b1, 8'd0);
        sample(seg[3], 10, 10); e_valid++;
        step_chk("skip.d3", 4'd3, 1'b1, 8'd0);
        sample(seg[5], 10, 10); e_valid++; e_seq++;
        step_chk("skip.d5", 4'd5, 1'b0, 8'd1);
        for (int d = 6; d <= 9; d++) begin
            sample(seg[d], 10, 10); e_valid++;
            step_chk($sformatf("relock%0d", d), 4'(d), (d == 9), 8'd1);
        end
        chk("relock.period", o_period, 20);

        // Bad patterns: blank bus and a digit beyond the modulus
        sample(7'h00, 10, 10); e_valid++; e_bad++;
        step_chk("bad00", 4'd9, 1'b0, 8'd2);
        sample(seg[3], 10, 10); e_valid++;
        step_chk("bad00.next", 4'd3, 1'b0, 8'd2);
        sample(seg[10], 10, 10); e_valid++; e_bad++;
        step_chk("badA", 4'd3, 1'b0, 8'd3);
        sample(seg[4], 10, 10); e_valid++;
        step_chk("badA.next", 4'd4, 1'b0, 8'd3);
        sample(seg[5], 10, 10); e_valid++;
        step_chk("armed5", 4'd5, 1'b0, 8'd3);

        // Disabled across three periods: nothing moves
        @(negedge clk);
        i_ena = 1'b0;
        sample(seg[6], 10, 10);
        sample(seg[7], 10, 10);
        sample(seg[8], 10, 10);
        step_chk("ena0", 4'd5, 1'b0, 8'd3);
        chk("ena0.period", o_period, 20);
        i_ena = 1'b1;
        sample(seg[9], 10, 10); e_valid++; e_seq++;
        step_chk("reena", 4'd9, 1'b0, 8'd4);
        sample(seg[0], 10, 10); e_valid++;
        step_chk("reena.wrap", 4'd0, 1'b0, 8'd4);
        chk("reena.period", o_period, 20);

        // 300 injected errors saturate the counter
        for (int i = 0; i < 300; i++) begin
            sample(7'h00, 4, 4); e_valid++; e_bad++;
        end
        step_chk("errsat", 4'd0, 1'b0, 8'd255);
        chk("errsat.period", o_period, 8);

        // Long period saturates the measurement
        sample(seg[0], 33000, 33000); e_valid++;
        step_chk("long", 4'd0, 1'b0, 8'd255);
        chk("long.period", o_period, 8);
        sample(seg[1], 10, 10); e_valid++;
        step_chk("long.next", 4'd1, 1'b0, 8'd255);
        chk("long.sat", o_period, 16'hFFFF);
        sample(seg[2], 10, 10); e_valid++;
        chk("long.recover", o_period, 20);

        // Asynchronous reset in the middle of a period
        i_disp    = seg[3];
        i_div_clk = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.digit",  o_digit, 0);
        chk("arst.valid",  o_valid, 0);
        chk("arst.bad",    o_bad_pattern, 0);
        chk("arst.seq",    o_seq_err, 0);
        chk("arst.locked", o_locked, 0);
        chk("arst.err",    o_err_cnt, 0);
        chk("arst.period", o_period, 0);
        @(negedge clk);
        i_div_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        sample(seg[4], 10, 10); e_valid++;
        step_chk("post.rst1", 4'd4, 1'b0, 8'd0);
        chk("post.rst1.period", o_period, 0);
        sample(seg[5], 10, 10); e_valid++;
        step_chk("post.rst2", 4'd5, 1'b0, 8'd0);
        chk("post.rst2.period", o_period, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_monitor.md
# seg_monitor

Readback monitor for the seven-segment display path: it samples the divided clock and segment bus produced by the divider/counter/display chain, decodes each segment pattern back into a nibble, and checks that successive digits increment correctly. It also measures the divided-clock period in system clocks and reports a lock status and a saturating error count. It sits beside the display driver in the tile, on the same `clk` domain, as the receiving end of the segment interface for self-test and debug.

## Interface
- `MOD` — 10 — digit modulus; expected successor of `MOD-1` is 0 (legal 2..16)
- `LOCK_N` — 4 — consecutive good increments required for lock (1..15)
- `PERIOD_W` — 16 — width of period measurement
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream
- `i_ena`  in  1  enable; low freezes all state except synchronizers
- `i_div_clk`  in  1  divided clock from the display path; asynchronous to `clk`
- `i_disp`  in  7  segment bus, active-high, bit0=a … bit6=g
- `o_digit`  out  4  last successfully decoded digit
- `o_valid`  out  1  one-cycle pulse per sample taken
- `o_bad_pattern`  out  1  one-cycle pulse: sampled pattern not in decode table
- `o_seq_err`  out  1  one-cycle pulse: decoded digit is not expected successor
- `o_locked`  out  1  level: state is LOCKED
- `o_err_cnt`  out  8  total errors, saturates at 255
- `o_period`  out  PERIOD_W  clk cycles between last two rising edges of `i_div_clk`, saturating

## Operation
- Synchronizer: `i_div_clk` through 3 flops (s1,s2,s3); `i_disp` through 2 flops (d1,d2). Always run, even with `i_ena` low.
- Rise = s2 & ~s3; fall = ~s2 & s3. Segments sampled on fall (mid-period, bus stable).
- Decode table (hex pattern→digit): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F. Digits ≥ `MOD` treated as bad pattern.
- States: IDLE (no reference), ARMED (reference held, run count < `LOCK_N`), LOCKED.
- On fall with `i_ena`=1: `o_valid`=1, then:
  - bad pattern: `o_bad_pattern`=1, err+1, `o_digit` held, run=0, → IDLE.
  - IDLE, good: `o_digit`=d, run=0, → ARMED.
  - ARMED/LOCKED, good, d == successor(`o_digit`): `o_digit`=d, run+1 (saturate at `LOCK_N`); ARMED → LOCKED when run reaches `LOCK_N`.
  - ARMED/LOCKED, good, mismatch: `o_seq_err`=1, err+1, `o_digit`=d, run=0, → ARMED.
- successor(x) = (x == `MOD-1`) ? 0 : x+1.
- Period: counter cnt increments per enabled cycle, saturating at all-ones. On rise: if a previous rise has been seen, `o_period` ← cnt; cnt ← 1. First rise after reset only sets the seen flag.
- `i_ena`=0: state, counters, outputs hold; pulses forced 0; edges occurring while disabled are dropped.

## Timing
- Reset (async, immediate): `o_digit`=0, `o_valid`=0, `o_bad_pattern`=0, `o_seq_err`=0, `o_locked`=0, `o_err_cnt`=0, `o_period`=0, state IDLE, cnt=0, seen=0, sync flops 0.
- `i_div_clk` first sampled low at edge k → fall detected after edge k+1 → all outputs updated at edge k+2. Same 2-edge latency for rise→`o_period`.
- `i_disp` must be stable ≥2 clk before `i_div_clk` fall.
- Pulses last exactly one cycle; `o_locked` updates with `o_valid`.
- Errors are mutually exclusive per sample; `o_err_cnt` increments by at most 1 per sample.
- Reset mid-operation: everything returns to reset values; first rise after release does not update `o_period`.

## Test plan
- Reset: assert `rst_n`=0 asynchronously mid-count → all outputs 0 within same cycle, state IDLE.
- Clean count 0..9,0,1 at 20-clk div period → no errors, `o_locked` rises with 5th sample (4th good increment), `o_period`=20, digit wraps 9→0 cleanly.
- Skip 3→5 while locked → `o_seq_err` pulse, `o_err_cnt`=1, `o_locked`=0, next 6 accepted; lock regained after 4 more increments.
- Pattern 0x00 sampled → `o_bad_pattern` pulse, `o_digit` unchanged, state IDLE; next digit accepted without `o_seq_err`.
- `i_ena` low across 3 div periods → outputs frozen, no pulses; after re-enable first sample compared against held digit (expect `o_seq_err` if counter advanced).
- Div period 70000 clks, `PERIOD_W`=16 → `o_period`=0xFFFF; 300 injected errors → `o_err_cnt`=255.
